// File: rtl/uart_frame_pkg.sv
// Package: uart_frame_pkg
// Shared types and helpers for the multi-channel UART frame serializer.
//  - chan_state_e : per-channel FSM state encoding (2 bits)
//  - frame_len    : bytes per frame (sync + payload + checksum)
//  - idx_width    : width of the per-channel byte index counter
//  - xor_bytes    : XOR of the low n_bytes bytes of a word (checksum)
package uart_frame_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } chan_state_e;

    // Upper bound on payload width accepted by xor_bytes.
    localparam int unsigned MAX_DATA_BYTES = 32;
    localparam int unsigned MAX_DATA_W     = 8 * MAX_DATA_BYTES;

    function automatic int unsigned frame_len(input int unsigned data_bytes,
                                              input bit          sync_en,
                                              input bit          chk_en);
        return data_bytes + 32'(sync_en) + 32'(chk_en);
    endfunction

    // One extra code point so the counter can hold FRAME_LEN without wrapping.
    function automatic int unsigned idx_width(input int unsigned flen);
        return $clog2(flen + 1);
    endfunction

    function automatic logic [7:0] xor_bytes(input logic [MAX_DATA_W-1:0] word,
                                             input int unsigned           n_bytes);
        logic [7:0] acc;
        acc = '0;
        for (int unsigned k = 0; k < MAX_DATA_BYTES; k++) begin
            if (k < n_bytes) begin
                acc = acc ^ word[8*k +: 8];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/uart_frame_chan.sv
// Module: uart_frame_chan
// One channel of the frame serializer: FSM, payload snapshot and byte mux.
// Ports:
//  clk, rst      clock, synchronous active-low reset
//  data          payload word, byte k = data[8k+7:8k]
//  send, en      frame request and this channel's enable (sampled together)
//  tx_done_tick  UART reports the current byte as transmitted
//  tx_data       byte handed to the UART (held stable until the next tx_start)
//  tx_start      one-cycle load strobe for the UART
//  busy          frame in progress (ISSUE/WAIT)
//  frame_done    one-cycle pulse once the last byte is transmitted
//  send_drop     one-cycle pulse: an enabled send arrived while not idle
module uart_frame_chan
    import uart_frame_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 3,
    parameter bit          SYNC_EN    = 1'b1,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter bit          CHK_EN     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic                    send,
    input  logic                    en,
    input  logic                    tx_done_tick,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    send_drop
);

    localparam int unsigned      FRAME_LEN = frame_len(DATA_BYTES, SYNC_EN, CHK_EN);
    localparam int unsigned      IDX_W     = idx_width(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);

    chan_state_e             state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [8*DATA_BYTES-1:0] snap_q;
    logic [7:0]              chk_q;
    logic [7:0]              data_chk;

    assign data_chk = xor_bytes(MAX_DATA_W'(data), DATA_BYTES);

    // Byte order within a frame: [sync], payload LSB-first, [checksum].
    function automatic logic [7:0] frame_byte(input logic [8*DATA_BYTES-1:0] word,
                                              input logic [7:0]              chk,
                                              input logic [IDX_W-1:0]        idx);
        logic [7:0] b;
        b = chk;
        if (SYNC_EN && idx == '0) begin
            b = SYNC_BYTE;
        end else begin
            for (int unsigned k = 0; k < DATA_BYTES; k++) begin
                if (32'(idx) == k + 32'(SYNC_EN)) begin
                    b = word[8*k +: 8];
                end
            end
        end
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            snap_q     <= '0;
            chk_q      <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            send_drop  <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            send_drop  <= send && en && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (send && en) begin
                        snap_q   <= data;
                        chk_q    <= data_chk;
                        idx_q    <= '0;
                        // Snapshot is not visible yet, so the first byte comes from live data.
                        tx_data  <= frame_byte(data, data_chk, '0);
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (tx_done_tick) begin
                        if (idx_q == LAST_IDX) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state_q    <= StDone;
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            tx_data  <= frame_byte(snap_q, chk_q, idx_q + 1'b1);
                            tx_start <= 1'b1;
                            state_q  <= StIssue;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_serializer.sv
// Module: uart_frame_serializer
// Frame serializer feeding N_CH independent UART transmitters. A broadcast send
// snapshots the payload on every enabled idle channel; each channel then streams
// [sync] payload[checksum] paced by its own tx_done_tick.
// Ports:
//  clk, rst      clock, synchronous active-low reset
//  data          payload word shared by all channels
//  send, ch_en   broadcast frame request, per-channel enable
//  tx_done_tick  per-channel UART byte-complete pulse
//  tx_data       per-channel byte, channel c = tx_data[8c+7:8c]
//  tx_start      per-channel UART load strobe
//  busy          per-channel frame in progress
//  frame_done    per-channel end-of-frame pulse
//  send_drop     per-channel rejected-request pulse
module uart_frame_serializer
    import uart_frame_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 3,
    parameter int unsigned N_CH       = 2,
    parameter bit          SYNC_EN    = 1'b1,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter bit          CHK_EN     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic                    send,
    input  logic [N_CH-1:0]         ch_en,
    input  logic [N_CH-1:0]         tx_done_tick,
    output logic [8*N_CH-1:0]       tx_data,
    output logic [N_CH-1:0]         tx_start,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         frame_done,
    output logic [N_CH-1:0]         send_drop
);

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        uart_frame_chan #(
            .DATA_BYTES (DATA_BYTES),
            .SYNC_EN    (SYNC_EN),
            .SYNC_BYTE  (SYNC_BYTE),
            .CHK_EN     (CHK_EN)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .data         (data),
            .send         (send),
            .en           (ch_en[c]),
            .tx_done_tick (tx_done_tick[c]),
            .tx_data      (tx_data[8*c +: 8]),
            .tx_start     (tx_start[c]),
            .busy         (busy[c]),
            .frame_done   (frame_done[c]),
            .send_drop    (send_drop[c])
        );
    end

endmodule

// File: tb/tb_uart_frame_serializer.sv
module tb_uart_frame_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: default parameters (3 payload bytes, 2 channels, sync + checksum)
    logic        rst;
    logic [23:0] data;
    logic        send;
    logic [1:0]  ch_en;
    logic [1:0]  tick;
    logic [15:0] tx_data;
    logic [1:0]  tx_start, busy, frame_done, send_drop;

    // Minimal DUT: single byte, no sync, no checksum, one channel
    logic [7:0]  d5_data;
    logic        d5_send;
    logic [0:0]  d5_en, d5_tick;
    logic [7:0]  d5_tx_data;
    logic [0:0]  d5_tx_start, d5_busy, d5_fd, d5_drop;

    uart_frame_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .data         (data),
        .send         (send),
        .ch_en        (ch_en),
        .tx_done_tick (tick),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .busy         (busy),
        .frame_done   (frame_done),
        .send_drop    (send_drop)
    );

    uart_frame_serializer #(
        .DATA_BYTES (1),
        .N_CH       (1),
        .SYNC_EN    (1'b0),
        .SYNC_BYTE  (8'hA5),
        .CHK_EN     (1'b0)
    ) dut5 (
        .clk          (clk),
        .rst          (rst),
        .data         (d5_data),
        .send         (d5_send),
        .ch_en        (d5_en),
        .tx_done_tick (d5_tick),
        .tx_data      (d5_tx_data),
        .tx_start     (d5_tx_start),
        .busy         (d5_busy),
        .frame_done   (d5_fd),
        .send_drop    (d5_drop)
    );

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [7:0] exp_q [2][$];
    int         st_cnt   [2];
    int         fd_cnt   [2];
    int         fd_cycle [2];
    int         drop_cnt [2];
    int         cnt      [2];
    int         delay    [2];
    logic [1:0] resp_en;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample outputs at negedge, score bytes, model the UARTs.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cycle++;
        for (int c = 0; c < 2; c++) begin
            if (tx_start[c]) begin
                logic [31:0] e;
                st_cnt[c]++;
                e = 32'h1FF;  // impossible byte value flags an unexpected start
                if (exp_q[c].size() != 0) e = {24'h0, exp_q[c].pop_front()};
                check_eq($sformatf("ch%0d_byte%0d", c, st_cnt[c]), {24'h0, tx_data[8*c +: 8]}, e);
            end
            if (frame_done[c]) begin
                fd_cnt[c]++;
                fd_cycle[c] = cycle;
                check_eq($sformatf("ch%0d_busy_at_done", c), {31'h0, busy[c]}, 32'h0);
            end
            if (send_drop[c]) drop_cnt[c]++;
            if (resp_en[c]) begin
                tick[c] = 1'b0;
                if (cnt[c] != 0) begin
                    cnt[c]--;
                    if (cnt[c] == 0) tick[c] = 1'b1;
                end
                if (tx_start[c]) cnt[c] = delay[c];
            end
        end
    endtask

    task automatic push_frame(input int c, input logic [23:0] d);
        exp_q[c].push_back(8'hA5);
        exp_q[c].push_back(d[7:0]);
        exp_q[c].push_back(d[15:8]);
        exp_q[c].push_back(d[23:16]);
        exp_q[c].push_back(d[7:0] ^ d[15:8] ^ d[23:16]);
    endtask

    task automatic do_send(input logic [23:0] d, input logic [1:0] en, input logic [1:0] accept);
        data  = d;
        ch_en = en;
        send  = 1'b1;
        for (int c = 0; c < 2; c++) if (accept[c]) push_frame(c, d);
        step();
        send  = 1'b0;
        ch_en = 2'b00;
    endtask

    task automatic wait_fd(input int c, input int target, input int budget);
        int n = 0;
        while (fd_cnt[c] < target && n < budget) begin
            step();
            n++;
        end
        check_eq($sformatf("ch%0d_frame_done_count", c), fd_cnt[c], target);
    endtask

    task automatic wait_starts(input int c, input int target, input int budget);
        int n = 0;
        while (st_cnt[c] < target && n < budget) begin
            step();
            n++;
        end
        check_eq($sformatf("ch%0d_start_count", c), st_cnt[c], target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; data = '0; send = 1'b0; ch_en = '0; tick = '0;
        d5_data = '0; d5_send = 1'b0; d5_en = '0; d5_tick = '0;
        resp_en = 2'b11;
        for (int c = 0; c < 2; c++) begin
            st_cnt[c] = 0; fd_cnt[c] = 0; fd_cycle[c] = 0; drop_cnt[c] = 0;
            cnt[c] = 0; delay[c] = 4;
        end
        repeat (3) step();
        check_eq("reset_tx_data", {16'h0, tx_data}, 32'h0);
        check_eq("reset_ctrl", {24'h0, tx_start, busy, frame_done, send_drop}, 32'h0);
        rst = 1'b1;
        step();

        // 1: single channel frame
        do_send(24'h123456, 2'b01, 2'b01);
        check_eq("t1_first_start_latency", {30'h0, tx_start}, 32'h1);
        check_eq("t1_busy", {30'h0, busy}, 32'h1);
        wait_fd(0, 1, 100);
        check_eq("t1_ch0_starts", st_cnt[0], 5);
        check_eq("t1_ch1_silent", st_cnt[1], 0);
        check_eq("t1_queue_empty", exp_q[0].size(), 0);
        repeat (3) step();

        // 2: both channels, ch1 paced twice as slow
        delay[1] = 8;
        do_send(24'h123456, 2'b11, 2'b11);
        wait_fd(0, 2, 200);
        wait_fd(1, 1, 200);
        check_eq("t2_ch0_starts", st_cnt[0], 10);
        check_eq("t2_ch1_starts", st_cnt[1], 5);
        check_eq("t2_done_later_on_ch1", {31'h0, fd_cycle[1] > fd_cycle[0]}, 32'h1);
        repeat (3) step();

        // 3: send while in WAIT on byte 2 is dropped, frame unaffected
        do_send(24'h123456, 2'b01, 2'b01);
        wait_starts(0, 13, 100);
        step();
        do_send(24'hFFFFFF, 2'b01, 2'b00);
        check_eq("t3_send_drop", {30'h0, send_drop}, 32'h1);
        do_send(24'hFFFFFF, 2'b00, 2'b00);
        check_eq("t3_disabled_no_drop", {30'h0, send_drop}, 32'h0);
        wait_fd(0, 3, 100);
        check_eq("t3_drop_count", drop_cnt[0], 1);
        check_eq("t3_queue_empty", exp_q[0].size(), 0);
        repeat (3) step();

        // 4: reset during WAIT of byte 3 aborts silently
        do_send(24'h123456, 2'b01, 2'b01);
        wait_starts(0, 19, 100);
        step();
        rst = 1'b0;
        step();
        check_eq("t4_rst_tx_data", {16'h0, tx_data}, 32'h0);
        check_eq("t4_rst_ctrl", {24'h0, tx_start, busy, frame_done, send_drop}, 32'h0);
        rst = 1'b1;
        exp_q[0].delete();
        cnt[0] = 0;
        tick[0] = 1'b0;
        repeat (30) step();
        check_eq("t4_no_frame_done", fd_cnt[0], 3);
        do_send(24'h123456, 2'b01, 2'b01);
        check_eq("t4_restart_sync", {24'h0, tx_data[7:0]}, 32'hA5);
        wait_fd(0, 4, 100);
        repeat (3) step();

        // 6: ticks while IDLE and during ISSUE are ignored
        resp_en[0] = 1'b0;
        tick[0] = 1'b1;
        step();
        tick[0] = 1'b0;
        step();
        check_eq("t6_idle_tick", {30'h0, busy[0], tx_start[0]}, 32'h0);
        do_send(24'h123456, 2'b01, 2'b01);
        tick[0] = 1'b1;
        step();
        tick[0] = 1'b0;
        repeat (5) step();
        check_eq("t6_no_extra_start", st_cnt[0], 25);
        check_eq("t6_still_busy", {31'h0, busy[0]}, 32'h1);
        tick[0] = 1'b1;
        resp_en[0] = 1'b1;
        wait_fd(0, 5, 100);
        check_eq("t6_total_starts", st_cnt[0], 29);

        // 5: single-byte frames, plus send during DONE
        d5_data = 8'h3C;
        d5_en = 1'b1;
        d5_send = 1'b1;
        step();
        d5_send = 1'b0;
        check_eq("t5_start", {31'h0, d5_tx_start}, 32'h1);
        check_eq("t5_byte", {24'h0, d5_tx_data}, 32'h3C);
        step();
        check_eq("t5_wait_no_start", {31'h0, d5_tx_start}, 32'h0);
        check_eq("t5_busy", {31'h0, d5_busy}, 32'h1);
        step();
        d5_tick = 1'b1;
        step();
        d5_tick = 1'b0;
        check_eq("t5_frame_done", {31'h0, d5_fd}, 32'h1);
        check_eq("t5_busy_clear", {31'h0, d5_busy}, 32'h0);
        check_eq("t5_data_held", {24'h0, d5_tx_data}, 32'h3C);
        d5_send = 1'b1;
        step();
        d5_send = 1'b0;
        check_eq("t5_done_one_cycle", {31'h0, d5_fd}, 32'h0);
        check_eq("t5_drop_in_done", {31'h0, d5_drop}, 32'h1);
        check_eq("t5_no_start_from_done_send", {31'h0, d5_tx_start}, 32'h0);
        d5_data = 8'hC3;
        d5_send = 1'b1;
        step();
        d5_send = 1'b0;
        check_eq("t5_second_start", {31'h0, d5_tx_start}, 32'h1);
        check_eq("t5_second_byte", {24'h0, d5_tx_data}, 32'hC3);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
